// File: rtl/ffdown_pkg.sv
// Shared types and default sizing for the ffdown countdown timer.
package ffdown_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_MAXV  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ffdown_bcd.sv
// Combinational binary-to-two-digit decimal split; the caller registers the result.
module ffdown_bcd
    import ffdown_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [1:0]       tens,
    output logic [3:0]       units
);

    // Inputs never exceed MAXV, so the narrow digit casts never lose information.
    always_comb begin
        tens  = 2'(bin / WIDTH'(10));
        units = 4'(bin % WIDTH'(10));
    end

endmodule

// File: rtl/ffdown_timer.sv
// Loadable countdown timer with hold, terminal-count pulse and optional periodic reload.
module ffdown_timer
    import ffdown_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MAXV   = DEF_MAXV,
    parameter bit RELOAD = 1'b0
) (
    input  logic             ck,
    input  logic             rs,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             hold,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       tens,
    output logic [3:0]       units,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAXV);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] rv, rv_n, q_n, d_clamp;
    logic             tc_n;
    logic [1:0]       tens_n;
    logic [3:0]       units_n;

    assign d_clamp = (d > MAX_Q) ? MAX_Q : d;
    assign busy    = (state == RUN) || (state == HOLD);

    always_ff @(negedge ck or posedge rs) begin
        if (rs) state <= IDLE;
        else    state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        q_n     = q;
        rv_n    = rv;
        tc_n    = 1'b0;
        if (ld) begin
            rv_n    = d_clamp;
            q_n     = d_clamp;
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start && q != '0) state_n = RUN;
                RUN: begin
                    if (hold) begin
                        state_n = HOLD;
                    end else if (q > ONE_Q) begin
                        q_n = q - ONE_Q;
                    end else if (q == ONE_Q) begin
                        tc_n = 1'b1;
                        if (RELOAD) begin
                            q_n = rv;
                        end else begin
                            q_n     = '0;
                            state_n = DONE;
                        end
                    end
                end
                HOLD: if (!hold) state_n = RUN;
                DONE: begin
                    if (start && rv != '0) begin
                        q_n     = rv;
                        state_n = RUN;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Digits are derived from the next count so they register alongside q without skew.
    ffdown_bcd #(.WIDTH(WIDTH)) u_bcd (
        .bin   (q_n),
        .tens  (tens_n),
        .units (units_n)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(negedge ck or posedge rs) begin
        if (rs) begin
            q     <= '0;
            rv    <= '0;
            tc    <= 1'b0;
            tens  <= 2'd0;
            units <= 4'd0;
        end else begin
            q     <= q_n;
            rv    <= rv_n;
            tc    <= tc_n;
            tens  <= tens_n;
            units <= units_n;
        end
    end

endmodule
